// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM state codes,
// instruction field positions and the default reset fetch address.
package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } if_state_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential fetch advance; wraps silently at the top of the address space.
    function automatic logic [31:0] pc_inc(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory request bus: fetch side is master, memory side is slave.
interface ifetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, requests words from instruction
// memory and hands them to decode under a valid/ready handshake.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst,
    ifetch_unit_if.master        imem,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [31:0]          inst,
    output logic [5:0]           opcode,
    output logic [5:0]           funct,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 fetch_fault
);

    if_state_e   state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] inst_n, pc_n;
    logic        valid_n, fault_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            inst        <= 32'd0;
            pc          <= RESET_PC;
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            inst        <= inst_n;
            pc          <= pc_n;
            inst_valid  <= valid_n;
            fetch_fault <= fault_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        inst_n     = inst;
        pc_n       = pc;
        valid_n    = inst_valid;
        fault_n    = fetch_fault;
        case (state)
            S_IDLE: state_n = S_REQ;
            S_REQ, S_HOLD: begin
                // Redirect wins over a same-cycle ack or consume; the word is dropped.
                if (redirect) begin
                    valid_n = 1'b0;
                    inst_n  = 32'd0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        fault_n = 1'b1;
                        state_n = S_FAULT;
                    end else begin
                        fetch_pc_n = redirect_pc;
                        state_n    = S_REQ;
                    end
                end else if (state == S_REQ && imem.ack) begin
                    inst_n  = imem.rdata;
                    pc_n    = fetch_pc;
                    valid_n = 1'b1;
                    state_n = S_HOLD;
                end else if (state == S_HOLD && inst_ready) begin
                    fetch_pc_n = pc_inc(pc);
                    valid_n    = 1'b0;
                    state_n    = S_REQ;
                end
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_IDLE;
        endcase
    end

    assign imem.req  = (state == S_REQ);
    assign imem.addr = fetch_pc;
    assign opcode    = inst[OPCODE_MSB:OPCODE_LSB];
    assign funct     = inst[FUNCT_MSB:FUNCT_LSB];
    assign pc_plus4  = pc_inc(pc);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: stimulus pushes expected fetch addresses and
// consumed instructions into queues, a monitor pops and compares them.
module tb_ifetch_unit;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [5:0]  opc;
        logic [5:0]  fn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ack_auto, ack_f;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, pc, pc_plus4, redirect_pc;
    logic [5:0]  opcode, funct;
    logic        redirect, fetch_fault;

    int tests = 0;
    int fails = 0;

    logic [31:0] addr_q[$];
    exp_t        inst_q[$];

    always #5 clk = ~clk;

    ifetch_unit_if bus();

    // Memory word: opcode field carries addr[7:2], funct is fixed at 6'h21.
    assign bus.ack   = ack_auto ? bus.req : ack_f;
    assign bus.rdata = {bus.addr[7:2], 20'h0_0000, 6'h21};

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem(bus),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .opcode(opcode), .funct(funct), .pc(pc), .pc_plus4(pc_plus4),
        .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_inst(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4,
                            input logic [5:0] o, input logic [5:0] f);
        exp_t e;
        e.inst = i; e.pc = p; e.pc4 = p4; e.opc = o; e.fn = f;
        inst_q.push_back(e);
    endtask

    initial begin
        ack_auto = 1'b1; ack_f = 1'b0; inst_ready = 1'b1;
        redirect = 1'b0; redirect_pc = 32'd0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (bus.req && bus.ack) begin
                        if (addr_q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL unexpected_req: got addr %h expected no request", bus.addr);
                        end else chk("imem_addr", bus.addr, addr_q.pop_front());
                    end
                    if (inst_valid && inst_ready && !redirect) begin
                        if (inst_q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL unexpected_inst: got %h expected none", inst);
                        end else begin
                            exp_t e;
                            e = inst_q.pop_front();
                            chk("inst", inst, e.inst);
                            chk("pc", pc, e.pc);
                            chk("pc_plus4", pc_plus4, e.pc4);
                            chk("opcode", {26'd0, opcode}, {26'd0, e.opc});
                            chk("funct", {26'd0, funct}, {26'd0, e.fn});
                        end
                    end
                end
            end
        join_none

        // Reset state
        tick(); tick();
        chk("rst_req", bus.req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", pc, 0);
        chk("rst_fault", fetch_fault, 0);

        // Zero-wait memory, always ready
        addr_q.push_back(32'h0); addr_q.push_back(32'h4);
        addr_q.push_back(32'h8); addr_q.push_back(32'hC); addr_q.push_back(32'h10);
        exp_inst(32'h0000_0021, 32'h0, 32'h4, 6'h00, 6'h21);
        exp_inst(32'h0400_0021, 32'h4, 32'h8, 6'h01, 6'h21);
        exp_inst(32'h0800_0021, 32'h8, 32'hC, 6'h02, 6'h21);
        exp_inst(32'h0C00_0021, 32'hC, 32'h10, 6'h03, 6'h21);
        exp_inst(32'h1000_0021, 32'h10, 32'h14, 6'h04, 6'h21);
        rst = 1'b0;
        chk("idle_req", bus.req, 0);
        tick();
        chk("first_req", bus.req, 1);
        chk("first_addr", bus.addr, 32'h0);
        chk("first_valid", inst_valid, 0);
        tick();
        chk("pulse_valid", inst_valid, 1);
        chk("opcode0", {26'd0, opcode}, 0);
        chk("funct0", {26'd0, funct}, 32'h21);
        tick();
        chk("pulse_valid_low", inst_valid, 0);
        chk("addr4", bus.addr, 32'h4);
        for (int i = 0; i < 5; i++) tick();

        // Three wait cycles at 0x10
        ack_auto = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", bus.req, 1);
            chk("wait_addr", bus.addr, 32'h10);
            tick();
        end
        chk("ack_req", bus.req, 1);
        chk("ack_addr", bus.addr, 32'h10);
        ack_f = 1'b1; inst_ready = 1'b0;
        tick();
        ack_f = 1'b0;

        // Decode stall for five cycles
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", inst_valid, 1);
            chk("stall_req", bus.req, 0);
            chk("stall_inst", inst, 32'h1000_0021);
            chk("stall_pc", pc, 32'h10);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        chk("after_stall_req", bus.req, 1);
        chk("after_stall_addr", bus.addr, 32'h14);

        // Redirect colliding with ack
        addr_q.push_back(32'h14); addr_q.push_back(32'h40);
        ack_auto = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0; inst_ready = 1'b0;
        chk("redir_valid", inst_valid, 0);
        chk("redir_req", bus.req, 1);
        chk("redir_addr", bus.addr, 32'h40);
        tick();
        // Redirect colliding with consume
        chk("hold40_valid", inst_valid, 1);
        chk("hold40_inst", inst, 32'h4000_0021);
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect = 1'b0; ack_auto = 1'b0; ack_f = 1'b0;
        chk("redir2_valid", inst_valid, 0);
        chk("redir2_inst", inst, 0);
        chk("redir2_opcode", {26'd0, opcode}, 0);
        chk("redir2_funct", {26'd0, funct}, 0);
        chk("redir2_req", bus.req, 1);
        chk("redir2_addr", bus.addr, 32'h80);

        // Misaligned redirect
        redirect = 1'b1; redirect_pc = 32'h42;
        tick();
        chk("fault_set", fetch_fault, 1);
        chk("fault_req", bus.req, 0);
        chk("fault_valid", inst_valid, 0);
        chk("fault_inst", inst, 0);
        ack_f = 1'b1;
        for (int i = 0; i < 10; i++) begin
            redirect = (i % 2 == 0); redirect_pc = 32'h100;
            tick();
            chk("fault_hold_req", bus.req, 0);
            chk("fault_sticky", fetch_fault, 1);
        end
        redirect = 1'b0; ack_f = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("clr_fault", fetch_fault, 0);
        chk("clr_req", bus.req, 0);
        chk("clr_pc", pc, 0);
        tick();
        chk("restart_req", bus.req, 1);
        chk("restart_addr", bus.addr, 32'h0);

        // Reset during a request with a simultaneous ack
        rst = 1'b1; ack_f = 1'b1;
        tick();
        rst = 1'b0; ack_f = 1'b0;
        chk("midrst_valid", inst_valid, 0);
        chk("midrst_inst", inst, 0);
        chk("midrst_req", bus.req, 0);
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("top_addr", bus.addr, 32'hFFFF_FFFC);
        addr_q.push_back(32'hFFFF_FFFC);
        exp_inst(32'hFC00_0021, 32'hFFFF_FFFC, 32'h0000_0000, 6'h3F, 6'h21);
        ack_auto = 1'b1;
        tick();
        ack_auto = 1'b0;
        chk("top_valid", inst_valid, 1);
        chk("top_pc_plus4", pc_plus4, 32'h0);
        tick();
        chk("wrap_req", bus.req, 1);
        chk("wrap_addr", bus.addr, 32'h0);
        chk("wrap_fault", fetch_fault, 0);
        tick();

        chk("addr_q_drained", addr_q.size(), 0);
        chk("inst_q_drained", inst_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
